// File: rtl/con_pkg.sv
// Shared constants for the accumulator-CPU control sequencer: CON bit
// positions, ALU op codes, instruction opcodes and the sequencer states.
package con_pkg;

  // CON bit positions
  localparam int B_PC_MAR   = 0;
  localparam int B_PC_INC   = 1;
  localparam int B_IR_PC    = 2;
  localparam int B_MBR_IR   = 3;
  localparam int B_IR_MAR   = 4;
  localparam int B_MBR_BR   = 5;
  localparam int B_ACC_MBR  = 6;
  localparam int B_MEM_MBR  = 7;
  localparam int B_MBR_MEM  = 8;
  localparam int B_ALU_ACC  = 10;
  localparam int B_ALU_OP   = 11;  // 4-bit field, bits 14:11
  localparam int B_HALT     = 15;

  // ALU op codes
  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_ADD  = 4'd1;
  localparam logic [3:0] ALU_SUB  = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_NOT  = 4'd5;
  localparam logic [3:0] ALU_SHR  = 4'd6;
  localparam logic [3:0] ALU_SHL  = 4'd7;
  localparam logic [3:0] ALU_MPY  = 4'd8;
  localparam logic [3:0] ALU_PASS = 4'd9;

  // Instruction opcodes (IR[15:8])
  localparam logic [7:0] OP_STORE  = 8'h01;
  localparam logic [7:0] OP_LOAD   = 8'h02;
  localparam logic [7:0] OP_ADD    = 8'h03;
  localparam logic [7:0] OP_SUB    = 8'h04;
  localparam logic [7:0] OP_JMPGEZ = 8'h05;
  localparam logic [7:0] OP_JMP    = 8'h06;
  localparam logic [7:0] OP_HALT   = 8'h07;
  localparam logic [7:0] OP_MPY    = 8'h08;
  localparam logic [7:0] OP_AND    = 8'h0A;
  localparam logic [7:0] OP_OR     = 8'h0B;
  localparam logic [7:0] OP_NOT    = 8'h0C;
  localparam logic [7:0] OP_SHR    = 8'h0D;
  localparam logic [7:0] OP_SHL    = 8'h0E;

  typedef enum logic [3:0] {
    S_IDLE, S_FMAR, S_FREQ, S_FLAT, S_FIR, S_DEC, S_EMAR, S_RREQ,
    S_RLAT, S_RBR, S_ALU, S_WMBR, S_WREQ, S_JMP, S_HALT
  } state_t;

  // ALU operation used in the ALU state for a given opcode; LOAD passes BR through.
  function automatic logic [3:0] alu_op_of(input logic [7:0] op);
    logic [3:0] r;
    r = ALU_NONE;
    case (op)
      OP_LOAD: r = ALU_PASS;
      OP_ADD:  r = ALU_ADD;
      OP_SUB:  r = ALU_SUB;
      OP_AND:  r = ALU_AND;
      OP_OR:   r = ALU_OR;
      OP_NOT:  r = ALU_NOT;
      OP_SHR:  r = ALU_SHR;
      OP_SHL:  r = ALU_SHL;
      OP_MPY:  r = ALU_MPY;
      default: r = ALU_NONE;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/con_decode.sv
// Pure combinational map from (state, opcode) to the control word and the
// memory handshake / halt flags. Each state drives at most one writer per register.
module con_decode
  import con_pkg::*;
#(
  parameter int CON_W = 32,
  parameter int OP_W  = 8
) (
  input  state_t           state,
  input  logic [OP_W-1:0]  op,
  output logic [CON_W-1:0] con,
  output logic             mem_req,
  output logic             mem_we,
  output logic             halted
);

  // Per-state control word decode
  always_comb begin
    con     = '0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    halted  = 1'b0;
    case (state)
      S_FMAR: con[B_PC_MAR] = 1'b1;
      S_FREQ: mem_req = 1'b1;
      S_FLAT: begin
        con[B_MEM_MBR] = 1'b1;
        con[B_PC_INC]  = 1'b1;
      end
      S_FIR:  con[B_MBR_IR] = 1'b1;
      S_EMAR: con[B_IR_MAR] = 1'b1;
      S_RREQ: mem_req = 1'b1;
      S_RLAT: con[B_MEM_MBR] = 1'b1;
      S_RBR:  con[B_MBR_BR] = 1'b1;
      S_ALU: begin
        con[B_ALU_ACC]      = 1'b1;
        con[B_ALU_OP +: 4]  = alu_op_of(op[7:0]);
      end
      S_WMBR: con[B_ACC_MBR] = 1'b1;
      S_WREQ: begin
        mem_req        = 1'b1;
        mem_we         = 1'b1;
        con[B_MBR_MEM] = 1'b1;
      end
      S_JMP:  con[B_IR_PC] = 1'b1;
      S_HALT: begin
        con[B_HALT] = 1'b1;
        halted      = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/con_sequencer.sv
// Hardwired fetch/decode/execute sequencer for the 16-bit accumulator CPU.
//
// state | meaning
// IDLE  | after reset, nothing asserted
// FMAR  | PC -> MAR
// FREQ  | instruction read request, wait for MEM_ACK
// FLAT  | MEM -> MBR, PC + 1
// FIR   | MBR -> IR
// DEC   | latch opcode, branch
// EMAR  | IR[7:0] -> MAR (operand address)
// RREQ  | operand read request, wait for MEM_ACK
// RLAT  | MEM -> MBR
// RBR   | MBR -> BR
// ALU   | ALU result -> ACC
// WMBR  | ACC -> MBR
// WREQ  | write request, wait for MEM_ACK
// JMP   | IR[7:0] -> PC
// HALT  | stopped until reset
//
// Outputs are registered from the decode of the next state, so they line up
// with the state register without any input-to-output combinational path.
module con_sequencer
  import con_pkg::*;
#(
  parameter int CON_W = 32,
  parameter int OP_W  = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [OP_W-1:0]  IR_OP,
  input  logic             ACC_NEG,
  input  logic             MEM_ACK,
  output logic [CON_W-1:0] CON,
  output logic             MEM_REQ,
  output logic             MEM_WE,
  output logic             HALTED
);

  state_t           state, state_nxt;
  logic [OP_W-1:0]  op_q, op_nxt;
  logic [CON_W-1:0] con_nxt;
  logic             req_nxt, we_nxt, halted_nxt;

  assign op_nxt = (state == S_DEC) ? IR_OP : op_q;

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: state_nxt = S_FMAR;
      S_FMAR: state_nxt = S_FREQ;
      S_FREQ: state_nxt = MEM_ACK ? S_FLAT : S_FREQ;
      S_FLAT: state_nxt = S_FIR;
      S_FIR:  state_nxt = S_DEC;
      S_DEC: begin
        case (IR_OP)
          OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_MPY, OP_STORE:
                      state_nxt = S_EMAR;
          OP_NOT, OP_SHR, OP_SHL:
                      state_nxt = S_ALU;
          OP_JMP:     state_nxt = S_JMP;
          OP_JMPGEZ:  state_nxt = ACC_NEG ? S_FMAR : S_JMP;
          OP_HALT:    state_nxt = S_HALT;
          default:    state_nxt = S_FMAR;
        endcase
      end
      S_EMAR: state_nxt = (op_q == OP_STORE) ? S_WMBR : S_RREQ;
      S_RREQ: state_nxt = MEM_ACK ? S_RLAT : S_RREQ;
      S_RLAT: state_nxt = S_RBR;
      S_RBR:  state_nxt = S_ALU;
      S_ALU:  state_nxt = S_FMAR;
      S_WMBR: state_nxt = S_WREQ;
      S_WREQ: state_nxt = MEM_ACK ? S_FMAR : S_WREQ;
      S_JMP:  state_nxt = S_FMAR;
      S_HALT: state_nxt = S_HALT;
      default: state_nxt = S_IDLE;
    endcase
  end

  con_decode #(
    .CON_W (CON_W),
    .OP_W  (OP_W)
  ) u_decode (
    .state   (state_nxt),
    .op      (op_nxt),
    .con     (con_nxt),
    .mem_req (req_nxt),
    .mem_we  (we_nxt),
    .halted  (halted_nxt)
  );

  // State, opcode and registered outputs; reset wins over everything
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      op_q    <= '0;
      CON     <= '0;
      MEM_REQ <= 1'b0;
      MEM_WE  <= 1'b0;
      HALTED  <= 1'b0;
    end else begin
      state   <= state_nxt;
      op_q    <= op_nxt;
      CON     <= con_nxt;
      MEM_REQ <= req_nxt;
      MEM_WE  <= we_nxt;
      HALTED  <= halted_nxt;
    end
  end

endmodule

// File: tb/tb_con_sequencer.sv
// Bench for con_sequencer: builds the expected per-cycle control trace of each
// instruction from the transfer list of the instruction set, then steps the
// DUT through it cycle by cycle.
module tb_con_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  IR_OP;
  logic        ACC_NEG;
  logic        MEM_ACK;
  logic [31:0] CON;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic        HALTED;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [31:0] con;
    logic        req;
    logic        we;
    logic        halt;
    logic        ack;
    logic        dec;
  } step_t;

  step_t q[$];

  con_sequencer #(.CON_W(32), .OP_W(8)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .IR_OP   (IR_OP),
    .ACC_NEG (ACC_NEG),
    .MEM_ACK (MEM_ACK),
    .CON     (CON),
    .MEM_REQ (MEM_REQ),
    .MEM_WE  (MEM_WE),
    .HALTED  (HALTED)
  );

  always #5 CLK = ~CLK;

  function automatic logic [3:0] ref_alu(input logic [7:0] op);
    case (op)
      8'h02: return 4'd9;
      8'h03: return 4'd1;
      8'h04: return 4'd2;
      8'h0A: return 4'd3;
      8'h0B: return 4'd4;
      8'h0C: return 4'd5;
      8'h0D: return 4'd6;
      8'h0E: return 4'd7;
      8'h08: return 4'd8;
      default: return 4'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [34:0] exp);
    logic [34:0] obs;
    obs = {HALTED, MEM_WE, MEM_REQ, CON};
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed={halt,we,req,con}=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Non-request cycle: ACK is random since it must be ignored there.
  task automatic push(input logic [31:0] con, input logic halt, input logic dec);
    step_t s;
    s = '{con: con, req: 1'b0, we: 1'b0, halt: halt, ack: 1'($urandom_range(0, 1)), dec: dec};
    q.push_back(s);
  endtask

  // Request phase: MEM_REQ held for waits+1 cycles, ACK on the last one.
  task automatic push_req(input logic [31:0] con, input logic we, input int waits);
    step_t s;
    for (int i = 0; i <= waits; i++) begin
      s = '{con: con, req: 1'b1, we: we, halt: 1'b0, ack: (i == waits), dec: 1'b0};
      q.push_back(s);
    end
  endtask

  task automatic build(input logic [7:0] op, input logic neg, input int w_fetch,
                       input int w_exec, input int halt_cycles);
    push(32'h1, 1'b0, 1'b0);                  // PC -> MAR
    push_req(32'h0, 1'b0, w_fetch);           // instruction read
    push(32'h82, 1'b0, 1'b0);                 // MEM -> MBR, PC+1
    push(32'h8, 1'b0, 1'b0);                  // MBR -> IR
    push(32'h0, 1'b0, 1'b1);                  // decode
    case (op)
      8'h02, 8'h03, 8'h04, 8'h08, 8'h0A, 8'h0B: begin
        push(32'h10, 1'b0, 1'b0);
        push_req(32'h0, 1'b0, w_exec);
        push(32'h80, 1'b0, 1'b0);
        push(32'h20, 1'b0, 1'b0);
        push(32'h400 | (32'(ref_alu(op)) << 11), 1'b0, 1'b0);
      end
      8'h01: begin
        push(32'h10, 1'b0, 1'b0);
        push(32'h40, 1'b0, 1'b0);
        push_req(32'h100, 1'b1, w_exec);
      end
      8'h0C, 8'h0D, 8'h0E: push(32'h400 | (32'(ref_alu(op)) << 11), 1'b0, 1'b0);
      8'h06: push(32'h4, 1'b0, 1'b0);
      8'h05: if (!neg) push(32'h4, 1'b0, 1'b0);
      8'h07: for (int i = 0; i < halt_cycles; i++) push(32'h8000, 1'b1, 1'b0);
      default: ;
    endcase
  endtask

  // Called at a falling edge: check each step, then drive inputs for the next rising edge.
  task automatic run_q(input logic [7:0] op, input logic neg);
    step_t s;
    int idx;
    idx = 0;
    while (q.size() > 0) begin
      s = q.pop_front();
      chk($sformatf("op%02h_step%0d", op, idx), {s.halt, s.we, s.req, s.con});
      MEM_ACK = s.ack;
      IR_OP   = s.dec ? op : 8'($urandom);
      ACC_NEG = s.dec ? neg : 1'($urandom_range(0, 1));
      idx++;
      @(negedge CLK);
    end
  endtask

  task automatic run_instr(input logic [7:0] op, input logic neg, input int wf, input int we_);
    build(op, neg, wf, we_, 0);
    run_q(op, neg);
  endtask

  logic [7:0] ops [0:13];
  logic [7:0] op_r;
  int n_instr;

  initial begin
    ops = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h08,
            8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'hFF, 8'h00};
    RST = 1'b1; MEM_ACK = 1'b0; IR_OP = 8'h00; ACC_NEG = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("reset_state", 35'h0);
    RST = 1'b0;

    // IDLE cycle, then LOAD with zero-wait memory
    push(32'h0, 1'b0, 1'b0);
    build(8'h02, 1'b0, 0, 0, 0);
    run_q(8'h02, 1'b0);

    run_instr(8'h03, 1'b0, 0, 3);           // ADD, three wait cycles in RREQ
    run_instr(8'h01, 1'b0, 1, 2);           // STORE with waits
    run_instr(8'h05, 1'b0, 0, 0);           // JMPGEZ taken
    run_instr(8'h05, 1'b1, 0, 0);           // JMPGEZ not taken
    run_instr(8'h06, 1'b0, 2, 0);           // JMP
    run_instr(8'h0C, 1'b0, 0, 0);
    run_instr(8'h0D, 1'b1, 0, 0);
    run_instr(8'h0E, 1'b0, 0, 0);
    run_instr(8'hFF, 1'b0, 0, 0);           // unknown opcode acts as NOP

    n_instr = 40;
    for (int i = 0; i < n_instr; i++) begin
      op_r = ops[$urandom_range(0, 13)];
      if ($urandom_range(0, 7) == 0) op_r = 8'($urandom_range(16, 255));
      run_instr(op_r, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    // HALT persists with random ACKs; reset clears it in one cycle
    build(8'h07, 1'b0, 0, 0, 25);
    run_q(8'h07, 1'b0);
    RST = 1'b1; MEM_ACK = 1'b0;
    @(negedge CLK);
    chk("halt_reset", 35'h0);
    RST = 1'b0;

    // Reset on the same edge as an instruction-fetch ACK
    chk("idle_after_reset", 35'h0);
    @(negedge CLK);
    chk("fmar", {3'b000, 32'h1});
    @(negedge CLK);
    chk("freq", {3'b001, 32'h0});
    MEM_ACK = 1'b1; RST = 1'b1;
    @(negedge CLK);
    chk("rst_in_freq", 35'h0);
    MEM_ACK = 1'b0; RST = 1'b0;
    @(negedge CLK);
    chk("fmar_after_rst", {3'b000, 32'h1});
    @(negedge CLK);
    chk("freq_no_latch", {3'b001, 32'h0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/con_sequencer.md
# con_sequencer

Hardwired control sequencer for the 16-bit accumulator CPU. Each cycle it produces the 32-bit `CON` control word that drives the register-transfer datapath: PC, MAR, MBR, IR, BR and the ACC/ALU. `CON[5]` is the MBR→BR load. It runs the fetch / decode / execute cycle per instruction and handshakes with memory. The block sits between IR/ACC and every datapath register's `CON` input.

## Interface
- `CON_W`, default 32: control word width; fixed.
- `OP_W`, default 8: opcode width (IR[15:8]).
- `CLK` in 1: system clock; all state changes on rising edge.
- `RST` in 1: reset. It is synchronous and active-high: it is sampled only on the rising `CLK` edge and takes priority over everything else.
- `IR_OP` in 8: opcode field of IR; sampled only in state DEC.
- `ACC_NEG` in 1: ACC[15]; sampled only in state DEC.
- `MEM_ACK` in 1: memory completion pulse; sampled only in FREQ/RREQ/WREQ.
- `CON` out 32: control word.
- `MEM_REQ` out 1: memory access request.
- `MEM_WE` out 1: write qualifier for `MEM_REQ`.
- `HALTED` out 1: high while in HALT.

## Operation
- Moore machine. `CON`, `MEM_REQ`, `MEM_WE` and `HALTED` are decoded from the state register and the latched opcode only. There are no combinational input→output paths.
- CON bit map:
  - 0: PC→MAR
  - 1: PC+1
  - 2: IR[7:0]→PC
  - 3: MBR→IR
  - 4: IR[7:0]→MAR
  - 5: MBR→BR
  - 6: ACC→MBR
  - 7: MEM→MBR
  - 8: MBR→MEM data
  - 10: ALU result→ACC
  - 14:11: ALU op
  - 15: halt
  - 9 and 31:16: reserved, always 0.
- ALU op encoding: ADD=1, SUB=2, AND=3, OR=4, NOT=5, SHR=6, SHL=7, MPY=8, PASS_BR=9.
- Opcodes: STORE=01, LOAD=02, ADD=03, SUB=04, JMPGEZ=05, JMP=06, HALT=07, MPY=08, AND=0A, OR=0B, NOT=0C, SHR=0D, SHL=0E (all hex).
- State transitions, with the CON bits each state asserts:
  - IDLE (CON=0) → FMAR.
  - FMAR {0} → FREQ.
  - FREQ {MEM_REQ} waits for ACK, then → FLAT.
  - FLAT {7,1} → FIR.
  - FIR {3} → DEC.
  - DEC (CON=0): latch `IR_OP` into an opcode register, then branch:
    - LOAD/ADD/SUB/AND/OR/MPY → EMAR
    - STORE → EMAR
    - NOT/SHR/SHL → ALU
    - JMP → JMP
    - JMPGEZ → JMP if `ACC_NEG`=0, else FMAR
    - HALT → HALT
    - unknown opcode → FMAR (NOP).
  - EMAR {4} → WMBR if STORE, else RREQ.
  - RREQ {MEM_REQ} waits for ACK, then → RLAT.
  - RLAT {7} → RBR.
  - RBR {5} → ALU.
  - ALU {10, op}; LOAD uses PASS_BR → FMAR.
  - WMBR {6} → WREQ.
  - WREQ {MEM_REQ, MEM_WE, 8} waits for ACK, then → FMAR.
  - JMP {2} → FMAR.
  - HALT {15} is absorbing; only `RST` leaves it.

## Timing
- Reset values: state IDLE, `CON`=0, `MEM_REQ`=0, `MEM_WE`=0, `HALTED`=0, opcode register=0.
- `RST` high at any edge, including mid-fetch, mid-wait or HALT: the next state is IDLE. `MEM_REQ` is low the cycle after the edge, and no `CON[7]` pulse follows a pending ACK.
- Request states: `MEM_REQ` holds high until the edge on which `MEM_ACK`=1. The transition happens on that edge, so the minimum dwell is 1 cycle. ACK in any other state is ignored.
- Latencies with a zero-wait memory (ACK in the first REQ cycle):
  - Fetch + decode: 5 cycles (FMAR, FREQ, FLAT, FIR, DEC).
  - LOAD/ADD: 10 cycles.
  - STORE: 8 cycles.
  - NOT/SHR/SHL: 6 cycles.
  - JMP: 6 cycles.
  - JMPGEZ not taken: 5 cycles.
- Each wait cycle adds 1 cycle.
- PC increments exactly once per instruction, in FLAT. A jump overrides it later, in JMP.
- `CON` bits are one-hot per transfer. No state asserts two writers to the same register.

## Structure
- Package `con_pkg` holds: the CON bit index constants, the ALU op codes, the opcode constants, and the state enum (4-bit, 15 states).
- Sub-module `con_decode` is a pure combinational map (state, opcode) → `CON`, `MEM_REQ`, `MEM_WE`, `HALTED`.
- The top level holds the state register, the opcode register and the next-state logic.

## Test plan
- Reset then run, with zero-wait memory and opcode 02 (LOAD): CON sequence 0, 0x1, 0 (REQ), 0x82, 0x8, 0, 0x10, 0 (REQ), 0x80, 0x20, 0x4C00; then FMAR.
- ADD with 3 wait cycles in RREQ: `MEM_REQ` high for 4 cycles, then `CON`=0x80, 0x20, 0x0C00; total 13 cycles.
- STORE: WREQ shows `MEM_REQ`=1, `MEM_WE`=1, `CON`=0x100 until ACK; WMBR shows `CON`=0x40.
- JMPGEZ: with `ACC_NEG`=0, `CON`=0x4 follows DEC; with `ACC_NEG`=1, `CON`=0x1 follows DEC (next fetch).
- HALT (07): `HALTED`=1 and `CON`=0x8000 persist for 20+ cycles while ACK pulses are ignored; `RST` returns `CON` to 0 next cycle.
- `RST` asserted during FREQ with ACK on the same edge: the next state is IDLE, `MEM_REQ`=0, and no 0x82 appears. Unknown opcode FF returns to FMAR right after DEC.
